// File: rtl/ctrl_shadow_pipe_reg_pkg.sv
// Shared constants and helpers for the shadowed control register.
// Package ctrl_reg_pkg: size limits and the even-parity helper.
package ctrl_reg_pkg;

    localparam int DEPTH_MAX = 4;
    localparam int WIDTH_MAX = 32;

    // Parity bit that makes the total count of ones even.
    function automatic logic even_par(input logic [WIDTH_MAX-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ctrl_shadow_pipe_reg_if.sv
// Control-word bus between the software side and the slice datapath.
// Signals: CECTRL, D, LOAD, COMMIT in; Q_MUX, PENDING, CHANGED out;
// FORCE_PERR/PERR only when CTRL_PARITY_EN is defined.
interface ctrl_shadow_pipe_reg_if #(
    parameter int WIDTH = 8
);
    logic             CECTRL;
    logic [WIDTH-1:0] D;
    logic             LOAD;
    logic             COMMIT;
    logic [WIDTH-1:0] Q_MUX;
    logic             PENDING;
    logic             CHANGED;
`ifdef CTRL_PARITY_EN
    logic             FORCE_PERR;
    logic             PERR;

    modport master (
        output CECTRL, D, LOAD, COMMIT, FORCE_PERR,
        input  Q_MUX, PENDING, CHANGED, PERR
    );
    modport slave (
        input  CECTRL, D, LOAD, COMMIT, FORCE_PERR,
        output Q_MUX, PENDING, CHANGED, PERR
    );
`else
    modport master (
        output CECTRL, D, LOAD, COMMIT,
        input  Q_MUX, PENDING, CHANGED
    );
    modport slave (
        input  CECTRL, D, LOAD, COMMIT,
        output Q_MUX, PENDING, CHANGED
    );
`endif
endinterface

// File: rtl/ctrl_shadow_pipe_reg_stage.sv
// One delay-line register with clock enable and sync reset to RST_VAL.
// Ports: CLK, RSTCTRL, CE, d (W bits) in; q (W bits) out.
module ctrl_pipe_stage #(
    parameter int           W       = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RSTCTRL,
    input  logic         CE,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK) begin
        if (RSTCTRL)
            q <= RST_VAL;
        else if (CE)
            q <= d;
    end

endmodule

// File: rtl/ctrl_shadow_pipe_reg.sv
// Double-buffered control register with a DEPTH-stage delay line.
// Ports: CLK, RSTCTRL, bus (slave: CECTRL/D/LOAD/COMMIT -> Q_MUX/PENDING/
// CHANGED). Optional parity (FORCE_PERR/PERR) under CTRL_PARITY_EN.
module ctrl_shadow_pipe_reg
    import ctrl_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 1,
    parameter int               REG_EN  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                  CLK,
    input  logic                  RSTCTRL,
    ctrl_shadow_pipe_reg_if.slave bus
);

`ifdef CTRL_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] prev_q;

    generate
        if (REG_EN != 0) begin : g_reg
`ifdef CTRL_PARITY_EN
            localparam logic [PW-1:0] RST_W =
                {even_par(WIDTH_MAX'(RST_VAL)), RST_VAL};
`else
            localparam logic [PW-1:0] RST_W = RST_VAL;
`endif
            logic [PW-1:0]             d_w;
            logic [PW-1:0]             shadow;
            logic [PW-1:0]             active;
            logic                      pending;
            logic [DEPTH-1:0][PW-1:0]  stg;

`ifdef CTRL_PARITY_EN
            // FORCE_PERR corrupts the stored parity to exercise PERR.
            assign d_w = {even_par(WIDTH_MAX'(bus.D)) ^ bus.FORCE_PERR,
                          bus.D};
`else
            assign d_w = bus.D;
`endif

            always_ff @(posedge CLK) begin
                if (RSTCTRL) begin
                    shadow  <= RST_W;
                    active  <= RST_W;
                    pending <= 1'b0;
                end else if (bus.CECTRL) begin
                    if (bus.LOAD)
                        shadow <= d_w;
                    // LOAD+COMMIT writes D straight through.
                    if (bus.COMMIT)
                        active <= bus.LOAD ? d_w : shadow;
                    if (bus.COMMIT)
                        pending <= 1'b0;
                    else if (bus.LOAD)
                        pending <= 1'b1;
                end
            end

            assign stg[0] = active;

            for (genvar i = 1; i < DEPTH; i++) begin : g_stg
                ctrl_pipe_stage #(
                    .W       (PW),
                    .RST_VAL (RST_W)
                ) u_stage (
                    .CLK     (CLK),
                    .RSTCTRL (RSTCTRL),
                    .CE      (bus.CECTRL),
                    .d       (stg[i-1]),
                    .q       (stg[i])
                );
            end

            assign q_w         = stg[DEPTH-1][WIDTH-1:0];
            assign bus.PENDING = pending;

`ifdef CTRL_PARITY_EN
            logic perr;
            // Odd total ones at the output means a corrupted word.
            always_ff @(posedge CLK) begin
                if (RSTCTRL)
                    perr <= 1'b0;
                else if (^stg[DEPTH-1])
                    perr <= 1'b1;
            end
            assign bus.PERR = perr;
`endif
        end else begin : g_byp
            assign q_w         = bus.D;
            assign bus.PENDING = 1'b0;
`ifdef CTRL_PARITY_EN
            assign bus.PERR    = 1'b0;
`endif
        end
    endgenerate

    // Ungated by CECTRL so CHANGED is a single-cycle strobe.
    always_ff @(posedge CLK) begin
        if (RSTCTRL)
            prev_q <= RST_VAL;
        else
            prev_q <= q_w;
    end

    assign bus.Q_MUX   = q_w;
    assign bus.CHANGED = (q_w != prev_q);

endmodule

// File: tb/tb_ctrl_shadow_pipe_reg.sv
// Bench for ctrl_shadow_pipe_reg: WIDTH=8, DEPTH=3, RST_VAL=8'h3C.
// Scoreboard of expected outputs from a behavioural model.
module tb_ctrl_shadow_pipe_reg;

    localparam logic [7:0] RV = 8'h3C;

    typedef struct packed {
        logic [7:0] q;
        logic       pend;
        logic       chg;
        logic       perr;
    } exp_t;

    logic CLK;
    logic RSTCTRL;

    ctrl_shadow_pipe_reg_if #(.WIDTH(8)) bus ();

    ctrl_shadow_pipe_reg #(
        .WIDTH   (8),
        .DEPTH   (3),
        .REG_EN  (1),
        .RST_VAL (RV)
    ) dut (
        .CLK     (CLK),
        .RSTCTRL (RSTCTRL),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;

    exp_t sb[$];

    logic [8:0] m_sh, m_act, m_s1, m_s2;
    logic [7:0] m_prev;
    logic       m_pend, m_perr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ce, input logic ld,
                        input logic cm, input logic [7:0] d,
                        input logic fp);
        logic [8:0] dx;
        exp_t e;
        RSTCTRL    = rst;
        bus.CECTRL = ce;
        bus.LOAD   = ld;
        bus.COMMIT = cm;
        bus.D      = d;
`ifdef CTRL_PARITY_EN
        bus.FORCE_PERR = fp;
`endif
        dx = {(^d) ^ fp, d};
        if (rst) begin
            m_sh   = {^RV, RV};
            m_act  = m_sh;
            m_s1   = m_sh;
            m_s2   = m_sh;
            m_pend = 1'b0;
            m_prev = RV;
            m_perr = 1'b0;
        end else begin
            m_prev = m_s2[7:0];
            if (^m_s2)
                m_perr = 1'b1;
            if (ce) begin
                m_s2 = m_s1;
                m_s1 = m_act;
                if (ld && cm) begin
                    m_sh   = dx;
                    m_act  = dx;
                    m_pend = 1'b0;
                end else if (cm) begin
                    m_act  = m_sh;
                    m_pend = 1'b0;
                end else if (ld) begin
                    m_sh   = dx;
                    m_pend = 1'b1;
                end
            end
        end
        e.q    = m_s2[7:0];
        e.pend = m_pend;
        e.chg  = (m_s2[7:0] != m_prev);
        e.perr = m_perr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("q_mux", 32'(bus.Q_MUX), 32'(e.q));
        chk("pending", 32'(bus.PENDING), 32'(e.pend));
        chk("changed", 32'(bus.CHANGED), 32'(e.chg));
`ifdef CTRL_PARITY_EN
        chk("perr", 32'(bus.PERR), 32'(e.perr));
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        RSTCTRL    = 1'b1;
        bus.CECTRL = 1'b0;
        bus.LOAD   = 1'b0;
        bus.COMMIT = 1'b0;
        bus.D      = '0;
`ifdef CTRL_PARITY_EN
        bus.FORCE_PERR = 1'b0;
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
        chk("rst_q", 32'(bus.Q_MUX), 32'(RV));
        chk("rst_chg", 32'(bus.CHANGED), 0);

        // LOAD, wait, COMMIT
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
        chk("t1_pend", 32'(bus.PENDING), 1);
        idle();
        chk("t1_pend2", 32'(bus.PENDING), 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("t1_pend0", 32'(bus.PENDING), 0);
        idle();
        chk("t1_notyet", 32'(bus.Q_MUX), 32'(RV));
        idle();
        chk("t1_q", 32'(bus.Q_MUX), 32'h5A);
        chk("t1_chg", 32'(bus.CHANGED), 1);
        idle();
        chk("t1_chg_off", 32'(bus.CHANGED), 0);

        // write-through
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0);
        chk("t2_pend", 32'(bus.PENDING), 0);
        idle();
        idle();
        chk("t2_q", 32'(bus.Q_MUX), 32'h11);

        // CE low ignores LOAD/COMMIT
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        chk("t3_q", 32'(bus.Q_MUX), 32'h11);
        chk("t3_chg", 32'(bus.CHANGED), 0);
        idle();
        idle();
        idle();
        chk("t3_noqueue", 32'(bus.Q_MUX), 32'h11);

        // back-to-back commits
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0);
        chk("t4_q1", 32'(bus.Q_MUX), 32'h01);
        chk("t4_c1", 32'(bus.CHANGED), 1);
        idle();
        chk("t4_q2", 32'(bus.Q_MUX), 32'h02);
        chk("t4_c2", 32'(bus.CHANGED), 1);
        idle();
        chk("t4_q3", 32'(bus.Q_MUX), 32'h03);
        chk("t4_c3", 32'(bus.CHANGED), 1);

        // reset during flush
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t5_q", 32'(bus.Q_MUX), 32'(RV));
        chk("t5_pend", 32'(bus.PENDING), 0);
        repeat (3) begin
            idle();
            chk("t5_noa5", 32'(bus.Q_MUX == 8'hA5), 0);
        end

`ifdef CTRL_PARITY_EN
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        idle();
        chk("t6_q", 32'(bus.Q_MUX), 32'h0F);
        chk("t6_perr0", 32'(bus.PERR), 0);
        idle();
        chk("t6_perr1", 32'(bus.PERR), 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
        idle();
        idle();
        idle();
        chk("t6_sticky", 32'(bus.PERR), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t6_clr", 32'(bus.PERR), 0);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 8'($urandom),
                 $urandom_range(0, 30) == 0);
        end

        chk("sb_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
